css_mcu0_el2_dma_addr_rsp: RTL and testbench
============================================

CSS_MCU0_EL2_DMA_ADDR_RSP -- requirements
Module: css_mcu0_el2_dma_addr_rsp

Interface
REQ-001 SHALL have parameter DCCM_SADR, default 32'hF004_0000, DCCM base byte address.
REQ-002 SHALL have parameter DCCM_SIZE, default 64, DCCM size in KB; power of two.
REQ-003 SHALL have parameter PIC_BASE_ADDR, default 32'hF00C_0000, PIC base byte address.
REQ-004 SHALL have parameter PIC_SIZE, default 32, PIC size in KB; power of two.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port rst_l, input, 1, asynchronous active-low reset.
REQ-007 SHALL have inbound request ports req_valid (in, 1), req_ready (out, 1), req_addr (in, 32), req_size (in, 3; 0 byte, 1 half, 2 word, 3 dword), req_write (in, 1), req_wdata (in, 64), req_tag (in, 4).
REQ-008 SHALL have forward ports dma_valid (out, 1), dma_ready (in, 1), dma_addr (out, 32), dma_size (out, 3), dma_write (out, 1), dma_wdata (out, 64).
REQ-009 SHALL have core-return ports dma_rsp_valid (in, 1), dma_rsp_data (in, 64), dma_rsp_err (in, 1; uncorrectable ECC).
REQ-010 SHALL have response ports rsp_valid (out, 1), rsp_ready (in, 1), rsp_err (out, 1), rsp_code (out, 3), rsp_rdata (out, 64), rsp_tag (out, 4).
REQ-011 SHALL have port err_count, output, 8, saturating count of error responses.

Function
REQ-012 SHALL implement FSM states IDLE, FWD, WAIT, RESP, with one request outstanding at a time.
REQ-013 SHALL drive req_ready=1 only in IDLE; a request is accepted on req_valid & req_ready.
REQ-014 SHALL register addr, size, write, wdata and tag on accept, and SHALL compute end = addr + (1<<size) - 1 mod 2^32 (wrap allowed).
REQ-015 SHALL classify the registered request in the accept cycle; classification priority, highest first:
- code 2 misaligned: size>3, or addr not a multiple of 1<<size
- code 1 unmapped: start and end not both in DCCM and not both in PIC (this covers DCCM-to-PIC crossings and end wrap)
- code 3 PIC width: request is in PIC and size != 2
- code 0: OK
REQ-016 SHALL transition IDLE->RESP on accept with code!=0, and IDLE->FWD on accept with code==0.
REQ-017 SHALL hold dma_valid=1 with stable dma_* in FWD, and go FWD->WAIT on dma_ready.
REQ-018 SHALL go WAIT->RESP on dma_rsp_valid, capturing dma_rsp_data; dma_rsp_err=1 sets code 4.
REQ-019 SHALL ignore dma_rsp_valid outside WAIT.
REQ-020 SHALL hold rsp_valid=1 in RESP with stable rsp_*, and go RESP->IDLE on rsp_ready.
REQ-021 SHALL set rsp_err = (rsp_code != 0) and rsp_tag = the captured tag.
REQ-022 SHALL set rsp_rdata to zero for writes and for codes 1-3, and to the captured data otherwise (including code 4).
REQ-023 SHALL make latency accept->rsp_valid exactly 1 cycle for errors, and accept->dma_valid exactly 1 cycle for OK requests.
REQ-024 SHALL increment err_count by 1 on each rsp_valid & rsp_ready with rsp_err=1, saturating at 8'hFF.

Reset
REQ-025 SHALL on rst_l=0, asynchronously and at any point mid-transaction, go to IDLE and drive req_ready=1, dma_valid=0, rsp_valid=0, rsp_err=0, rsp_code=0, rsp_rdata=0, rsp_tag=0, err_count=0.
REQ-026 SHALL discard any in-flight request at reset, and SHALL not produce a response for it after reset release.

Verification
REQ-027 SHALL be verified for an OK read: read, addr 0xF004_0010, size 2, tag 5; dma_rsp_data=0x1234 -> dma_valid 1 cycle after accept; rsp_code=0, rsp_rdata=0x1234, rsp_tag=5.
REQ-028 SHALL be verified for boundary crossing: addr 0xF004_FFFC, size 3 -> rsp_code=2 (misaligned). Then addr 0xF004_FFF8, size 3 -> code 0. Then addr 0xF005_0000, size 0 -> code 1. In all three cases no dma_valid accompanies an error response.
REQ-029 SHALL be verified for PIC access width: addr 0xF00C_0004, size 2 -> code 0, forwarded. Then addr 0xF00C_0004, size 0 -> rsp_code=3, rsp_valid 1 cycle after accept.
REQ-030 SHALL be verified for backpressure: dma_ready low for 5 cycles, then rsp_ready low for 3 cycles -> dma_* and rsp_* stay stable, req_ready stays 0, and the response completes once.
REQ-031 SHALL be verified for counting: 300 error responses -> err_count=0xFF. A dma_rsp_err=1 response -> code 4 with data passed through.
REQ-032 SHALL be verified for reset in WAIT: rst_l pulsed low in WAIT -> all outputs at reset values; a late dma_rsp_valid is ignored.

Source files
------------

// File: rtl/css_mcu0_el2_dma_addr_rsp.sv
// DMA address checker: classifies one request against DCCM/PIC windows, forwards
// legal requests to the core and returns a tagged response with an error code.
//   state | meaning
//   IDLE  | ready for a new request
//   FWD   | request presented on dma_*, waiting for dma_ready
//   WAIT  | forwarded, waiting for dma_rsp_valid from the core
//   RESP  | response presented on rsp_*, waiting for rsp_ready
module css_mcu0_el2_dma_addr_rsp #(
  parameter logic [31:0] DCCM_SADR     = 32'hF004_0000,
  parameter int unsigned DCCM_SIZE     = 64,
  parameter logic [31:0] PIC_BASE_ADDR = 32'hF00C_0000,
  parameter int unsigned PIC_SIZE      = 32
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic        req_write,
  input  logic [63:0] req_wdata,
  input  logic [3:0]  req_tag,
  output logic        dma_valid,
  input  logic        dma_ready,
  output logic [31:0] dma_addr,
  output logic [2:0]  dma_size,
  output logic        dma_write,
  output logic [63:0] dma_wdata,
  input  logic        dma_rsp_valid,
  input  logic [63:0] dma_rsp_data,
  input  logic        dma_rsp_err,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_err,
  output logic [2:0]  rsp_code,
  output logic [63:0] rsp_rdata,
  output logic [3:0]  rsp_tag,
  output logic [7:0]  err_count
);

  localparam logic [31:0] DCCM_BYTES = 32'(DCCM_SIZE * 1024);
  localparam logic [31:0] PIC_BYTES  = 32'(PIC_SIZE * 1024);

  localparam logic [2:0] CODE_OK    = 3'd0;
  localparam logic [2:0] CODE_UNMAP = 3'd1;
  localparam logic [2:0] CODE_ALIGN = 3'd2;
  localparam logic [2:0] CODE_PICW  = 3'd3;
  localparam logic [2:0] CODE_ECC   = 3'd4;

  typedef enum logic [1:0] {IDLE, FWD, WAIT, RESP} state_t;

  state_t      state_q;
  logic        req_ready_q;
  logic        dma_valid_q;
  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic        write_q;
  logic [63:0] wdata_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [2:0]  rsp_code_q;
  logic [63:0] rsp_rdata_q;
  logic [3:0]  rsp_tag_q;
  logic [7:0]  err_count_q;

  logic [2:0]  len_m1;
  logic [31:0] end_addr;
  logic        start_dccm, end_dccm, start_pic, end_pic;
  logic [2:0]  code_d;

  // Unsigned offset compare also rejects addresses below the base (they wrap high).
  function automatic logic in_win(input logic [31:0] a, input logic [31:0] base,
                                  input logic [31:0] bytes);
    return (a - base) < bytes;
  endfunction

  always_comb begin
    len_m1 = 3'd0;
    case (req_size[1:0])
      2'd0: len_m1 = 3'd0;
      2'd1: len_m1 = 3'd1;
      2'd2: len_m1 = 3'd3;
      2'd3: len_m1 = 3'd7;
      default: len_m1 = 3'd0;
    endcase
  end

  assign end_addr   = req_addr + {29'd0, len_m1};
  assign start_dccm = in_win(req_addr, DCCM_SADR, DCCM_BYTES);
  assign end_dccm   = in_win(end_addr, DCCM_SADR, DCCM_BYTES);
  assign start_pic  = in_win(req_addr, PIC_BASE_ADDR, PIC_BYTES);
  assign end_pic    = in_win(end_addr, PIC_BASE_ADDR, PIC_BYTES);

  always_comb begin
    code_d = CODE_OK;
    if (req_size[2] || (|(req_addr[2:0] & len_m1)))
      code_d = CODE_ALIGN;
    else if (!((start_dccm && end_dccm) || (start_pic && end_pic)))
      code_d = CODE_UNMAP;
    else if (start_pic && (req_size != 3'd2))
      code_d = CODE_PICW;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      dma_valid_q <= 1'b0;
      addr_q      <= '0;
      size_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_code_q  <= CODE_OK;
      rsp_rdata_q <= '0;
      rsp_tag_q   <= '0;
      err_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q      <= req_addr;
            size_q      <= req_size;
            write_q     <= req_write;
            wdata_q     <= req_wdata;
            rsp_tag_q   <= req_tag;
            req_ready_q <= 1'b0;
            if (code_d != CODE_OK) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_code_q  <= code_d;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q     <= FWD;
              dma_valid_q <= 1'b1;
            end
          end
        end
        FWD: begin
          if (dma_ready) begin
            dma_valid_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (dma_rsp_valid) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_code_q  <= dma_rsp_err ? CODE_ECC : CODE_OK;
            rsp_err_q   <= dma_rsp_err;
            rsp_rdata_q <= write_q ? 64'd0 : dma_rsp_data;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
            if (rsp_err_q && (err_count_q != 8'hFF))
              err_count_q <= err_count_q + 8'd1;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          dma_valid_q <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign dma_valid = dma_valid_q;
  assign dma_addr  = addr_q;
  assign dma_size  = size_q;
  assign dma_write = write_q;
  assign dma_wdata = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_code  = rsp_code_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_tag   = rsp_tag_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_css_mcu0_el2_dma_addr_rsp.sv
// Directed bench for css_mcu0_el2_dma_addr_rsp: hand-computed codes, latency,
// backpressure, error-count saturation and reset in WAIT.
module tb_css_mcu0_el2_dma_addr_rsp;

  logic        clk;
  logic        rst_l;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic        req_write;
  logic [63:0] req_wdata;
  logic [3:0]  req_tag;
  logic        dma_valid, dma_ready;
  logic [31:0] dma_addr;
  logic [2:0]  dma_size;
  logic        dma_write;
  logic [63:0] dma_wdata;
  logic        dma_rsp_valid;
  logic [63:0] dma_rsp_data;
  logic        dma_rsp_err;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [2:0]  rsp_code;
  logic [63:0] rsp_rdata;
  logic [3:0]  rsp_tag;
  logic [7:0]  err_count;

  int n_cmp;
  int n_bad;
  logic [7:0] exp_cnt;

  css_mcu0_el2_dma_addr_rsp dut (
    .clk(clk), .rst_l(rst_l),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_write(req_write), .req_wdata(req_wdata), .req_tag(req_tag),
    .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_addr(dma_addr),
    .dma_size(dma_size), .dma_write(dma_write), .dma_wdata(dma_wdata),
    .dma_rsp_valid(dma_rsp_valid), .dma_rsp_data(dma_rsp_data), .dma_rsp_err(dma_rsp_err),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err),
    .rsp_code(rsp_code), .rsp_rdata(rsp_rdata), .rsp_tag(rsp_tag),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, ".req_ready"}, req_ready, 1);
    chk({name, ".dma_valid"}, dma_valid, 0);
    chk({name, ".rsp_valid"}, rsp_valid, 0);
    chk({name, ".rsp_err"},   rsp_err,   0);
    chk({name, ".rsp_code"},  rsp_code,  0);
    chk({name, ".rsp_rdata"}, rsp_rdata, 0);
    chk({name, ".rsp_tag"},   rsp_tag,   0);
    chk({name, ".err_count"}, err_count, 0);
  endtask

  // One full transaction with no backpressure; codes 0 and 4 go through the core.
  task automatic run_txn(input string name, input logic [31:0] a, input logic [2:0] sz,
                         input logic wr, input logic [63:0] wd, input logic [3:0] tg,
                         input logic [2:0] exp_code, input logic [63:0] core_data,
                         input logic core_err, input logic [63:0] exp_rdata);
    logic fwd;
    fwd = (exp_code == 3'd0) || (exp_code == 3'd4);
    chk({name, ".req_ready"}, req_ready, 1);
    req_valid = 1'b1; req_addr = a; req_size = sz; req_write = wr;
    req_wdata = wd; req_tag = tg;
    step();
    req_valid = 1'b0;
    if (fwd) begin
      chk({name, ".dma_valid"}, dma_valid, 1);
      chk({name, ".dma_addr"},  dma_addr,  a);
      chk({name, ".dma_size"},  dma_size,  sz);
      chk({name, ".dma_write"}, dma_write, wr);
      chk({name, ".dma_wdata"}, dma_wdata, wd);
      chk({name, ".rsp_valid_early"}, rsp_valid, 0);
      dma_ready = 1'b1;
      step();
      dma_ready = 1'b0;
      chk({name, ".dma_done"}, dma_valid, 0);
      dma_rsp_valid = 1'b1; dma_rsp_data = core_data; dma_rsp_err = core_err;
      step();
      dma_rsp_valid = 1'b0; dma_rsp_err = 1'b0;
    end else begin
      chk({name, ".no_dma"}, dma_valid, 0);
    end
    chk({name, ".rsp_valid"}, rsp_valid, 1);
    chk({name, ".rsp_code"},  rsp_code,  exp_code);
    chk({name, ".rsp_err"},   rsp_err,   exp_code != 3'd0);
    chk({name, ".rsp_rdata"}, rsp_rdata, exp_rdata);
    chk({name, ".rsp_tag"},   rsp_tag,   tg);
    chk({name, ".req_busy"},  req_ready, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    if (exp_code != 3'd0 && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
    chk({name, ".rsp_done"},  rsp_valid, 0);
    chk({name, ".req_ready_after"}, req_ready, 1);
    chk({name, ".err_count"}, err_count, exp_cnt);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; exp_cnt = 8'd0;
    rst_l = 1'b0;
    req_valid = 0; req_addr = 0; req_size = 0; req_write = 0; req_wdata = 0; req_tag = 0;
    dma_ready = 0; dma_rsp_valid = 0; dma_rsp_data = 0; dma_rsp_err = 0; rsp_ready = 0;
    #23;
    chk_reset_vals("reset");
    rst_l = 1'b1;
    step();

    run_txn("ok_read", 32'hF004_0010, 3'd2, 0, 64'd0, 4'd5, 3'd0, 64'h1234, 0, 64'h1234);
    run_txn("dw_mis", 32'hF004_FFFC, 3'd3, 0, 64'd0, 4'd1, 3'd2, 64'd0, 0, 64'd0);
    run_txn("dw_top", 32'hF004_FFF8, 3'd3, 0, 64'd0, 4'd2, 3'd0,
            64'hDEAD_BEEF_0BAD_F00D, 0, 64'hDEAD_BEEF_0BAD_F00D);
    run_txn("past_dccm", 32'hF005_0000, 3'd0, 0, 64'd0, 4'd3, 3'd1, 64'd0, 0, 64'd0);
    run_txn("pic_word", 32'hF00C_0004, 3'd2, 1, 64'h55AA, 4'd4, 3'd0, 64'h9999, 0, 64'd0);
    run_txn("pic_byte", 32'hF00C_0004, 3'd0, 0, 64'd0, 4'd6, 3'd3, 64'd0, 0, 64'd0);
    run_txn("pic_dword", 32'hF00C_0008, 3'd3, 0, 64'd0, 4'd7, 3'd3, 64'd0, 0, 64'd0);
    run_txn("pic_last", 32'hF00C_7FFC, 3'd2, 0, 64'd0, 4'd8, 3'd0, 64'h77, 0, 64'h77);
    run_txn("past_pic", 32'hF00C_8000, 3'd2, 0, 64'd0, 4'd9, 3'd1, 64'd0, 0, 64'd0);
    run_txn("size5", 32'hF004_0000, 3'd5, 0, 64'd0, 4'hA, 3'd2, 64'd0, 0, 64'd0);
    run_txn("half_odd", 32'hF004_0001, 3'd1, 0, 64'd0, 4'hB, 3'd2, 64'd0, 0, 64'd0);
    run_txn("top_byte", 32'hFFFF_FFFF, 3'd0, 0, 64'd0, 4'hC, 3'd1, 64'd0, 0, 64'd0);
    run_txn("below_dccm", 32'hF003_FFF8, 3'd3, 0, 64'd0, 4'hD, 3'd1, 64'd0, 0, 64'd0);
    run_txn("wr_ecc", 32'hF004_0020, 3'd3, 1, 64'h1, 4'hE, 3'd4, 64'hFFFF, 1, 64'd0);

    // Backpressure on both handshakes.
    req_valid = 1'b1; req_addr = 32'hF004_0102; req_size = 3'd1; req_write = 1'b1;
    req_wdata = 64'hCAFE; req_tag = 4'd9;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp.dma_valid", dma_valid, 1);
      chk("bp.dma_addr",  dma_addr,  32'hF004_0102);
      chk("bp.dma_size",  dma_size,  1);
      chk("bp.dma_write", dma_write, 1);
      chk("bp.dma_wdata", dma_wdata, 64'hCAFE);
      chk("bp.req_ready", req_ready, 0);
      step();
    end
    dma_ready = 1'b1;
    step();
    dma_ready = 1'b0;
    chk("bp.dma_done", dma_valid, 0);
    dma_rsp_valid = 1'b1; dma_rsp_data = 64'h1111;
    step();
    dma_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp.rsp_valid", rsp_valid, 1);
      chk("bp.rsp_code",  rsp_code,  0);
      chk("bp.rsp_rdata", rsp_rdata, 0);
      chk("bp.rsp_tag",   rsp_tag,   9);
      chk("bp.req_ready2", req_ready, 0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp.rsp_once", rsp_valid, 0);
    step();
    chk("bp.rsp_once2", rsp_valid, 0);
    chk("bp.idle", req_ready, 1);

    for (int i = 0; i < 300; i++)
      run_txn("sat", 32'hF004_0002, 3'd2, 0, 64'd0, i[3:0], 3'd2, 64'd0, 0, 64'd0);
    chk("sat.final", err_count, 8'hFF);
    run_txn("rd_ecc", 32'hF004_0040, 3'd3, 0, 64'd0, 4'h3, 3'd4,
            64'h0123_4567_89AB_CDEF, 1, 64'h0123_4567_89AB_CDEF);

    // Reset while waiting for the core.
    req_valid = 1'b1; req_addr = 32'hF004_0200; req_size = 3'd2; req_write = 1'b0; req_tag = 4'hF;
    step();
    req_valid = 1'b0;
    dma_ready = 1'b1;
    step();
    dma_ready = 1'b0;
    chk("rst.in_wait", dma_valid, 0);
    #2 rst_l = 1'b0;
    #1;
    exp_cnt = 8'd0;
    chk_reset_vals("rst_wait");
    @(negedge clk);
    rst_l = 1'b1;
    step();
    dma_rsp_valid = 1'b1; dma_rsp_data = 64'hBAD;
    step();
    dma_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst.late_rsp", rsp_valid, 0);
      chk("rst.ready", req_ready, 1);
      step();
    end
    run_txn("post_rst", 32'hF004_0008, 3'd3, 0, 64'd0, 4'h2, 3'd0, 64'h42, 0, 64'h42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
